seven_segment_capture: RTL

//  Receive-side counterpart of the 4-digit multiplexed 7-segment driver: samples the scanned

---
 rtl/seven_segment_pkg.sv | 44 ++++
 rtl/seg7_pattern_decode.sv | 31 +++
 rtl/seven_segment_capture.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_pkg.sv
// Shared constants and types for the 7-segment capture path.
package seven_segment_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned DIGITS  = 4;
  localparam int unsigned BCD_W   = 4;
  localparam int unsigned COUNT_W = 14;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_e;

  // Slot index of a one-hot active-high digit select.
  function automatic logic [1:0] sel_index(input logic [DIGITS-1:0] sel);
    logic [1:0] idx;
    idx = 2'd0;
    case (sel)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Maps an active-high 7-segment pattern back to its BCD digit.
module seg7_pattern_decode
  import seven_segment_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic [BCD_W-1:0] digit,
  output logic             is_blank,
  output logic             is_invalid
);

  always_comb begin
    digit      = '0;
    is_blank   = 1'b0;
    is_invalid = 1'b0;
    case (seg)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: is_blank = 1'b1;
      default:   is_invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_segment_capture.sv
// Samples a scanned 4-digit 7-segment bus, rebuilds the BCD frame and converts it to binary.
module seven_segment_capture
  import seven_segment_pkg::*;
#(
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned SETTLE_CYCLES    = 4,
  parameter int unsigned TIMEOUT_CYCLES   = 2**20,
  parameter bit          DIGIT_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [DIGITS-1:0]      i_digitSelect,
  input  logic [7:0]             i_LED,
  output logic [DIGITS*BCD_W-1:0] o_BCD,
  output logic [COUNT_W-1:0]     o_count,
  output logic                   o_valid,
  output logic [DIGITS-1:0]      o_blankMask,
  output logic                   o_error,
  output logic                   o_overrun,
  output logic                   o_stale
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DIGITS-1:0] SEL_IDLE = DIGIT_ACTIVE_LOW ? 4'hF : 4'h0;

  logic unused_dp;
  assign unused_dp = i_LED[7];

  logic [SYNC_STAGES-1:0][DIGITS-1:0] sel_sync;
  logic [SYNC_STAGES-1:0][SEG_W-1:0]  seg_sync;
  logic [DIGITS-1:0] sel;
  logic [SEG_W-1:0]  seg;

  // Both buses share one synchronizer chain so a select and its segments stay aligned.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sel_sync <= {SYNC_STAGES{SEL_IDLE}};
      seg_sync <= '0;
    end else begin
      sel_sync[0] <= i_digitSelect;
      seg_sync[0] <= i_LED[SEG_W-1:0];
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sel_sync[i] <= sel_sync[i-1];
        seg_sync[i] <= seg_sync[i-1];
      end
    end
  end

  assign sel = DIGIT_ACTIVE_LOW ? ~sel_sync[SYNC_STAGES-1] : sel_sync[SYNC_STAGES-1];
  assign seg = SEG_ACTIVE_LOW   ? ~seg_sync[SYNC_STAGES-1] : seg_sync[SYNC_STAGES-1];

  logic [BCD_W-1:0] dec_digit;
  logic             dec_blank;
  logic             dec_invalid;

  seg7_pattern_decode u_decode (
    .seg        (seg),
    .digit      (dec_digit),
    .is_blank   (dec_blank),
    .is_invalid (dec_invalid)
  );

  logic [DIGITS-1:0]            prev_sel;
  logic [SET_W-1:0]             settle_cnt;
  logic                         captured;
  logic [DIGITS-1:0]            mask;
  logic [DIGITS-1:0][BCD_W-1:0] slot_bcd;
  logic [DIGITS-1:0]            slot_blank;
  logic                         err_flag;

  logic       sel_stable;
  logic       multi_sel;
  logic       capture_en;
  logic       frame_done;
  logic [1:0] cap_idx;

  assign sel_stable = (sel == prev_sel);
  assign multi_sel  = ($countones(sel) > 1);
  assign capture_en = sel_stable && $onehot(sel) && !captured &&
                      (settle_cnt == SET_W'(SETTLE_CYCLES - 2));
  assign frame_done = (mask == '1);
  assign cap_idx    = sel_index(sel);

  // Settle counting and slot capture; a completed frame clears the slot state for the next one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prev_sel   <= '0;
      settle_cnt <= '0;
      captured   <= 1'b0;
      mask       <= '0;
      slot_bcd   <= '0;
      slot_blank <= '0;
      err_flag   <= 1'b0;
    end else begin
      if (!sel_stable) begin
        prev_sel   <= sel;
        settle_cnt <= '0;
        captured   <= 1'b0;
      end else if ($onehot(sel) && !captured) begin
        if (capture_en) captured <= 1'b1;
        else            settle_cnt <= settle_cnt + SET_W'(1);
      end

      if (frame_done) begin
        mask       <= '0;
        slot_blank <= '0;
        err_flag   <= multi_sel;
      end else begin
        if (capture_en) begin
          slot_bcd[cap_idx]   <= dec_digit;
          slot_blank[cap_idx] <= dec_blank;
          mask[cap_idx]       <= 1'b1;
        end
        if ((capture_en && dec_invalid) || multi_sel) err_flag <= 1'b1;
      end
    end
  end

  conv_state_e                  state;
  logic [1:0]                   idx;
  logic [COUNT_W-1:0]           acc;
  logic [COUNT_W-1:0]           acc_next;
  logic [DIGITS-1:0][BCD_W-1:0] bcd_lat;
  logic [DIGITS-1:0]            blank_lat;
  logic                         valid_set;

  // acc*10 + digit via shifts; 9999 fits in 14 bits so no overflow guard is needed.
  assign acc_next  = (acc << 3) + (acc << 1) + COUNT_W'(bcd_lat[idx]);
  assign valid_set = (state == CONV) && (idx == 2'd0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      idx         <= '0;
      acc         <= '0;
      bcd_lat     <= '0;
      blank_lat   <= '0;
      o_BCD       <= '0;
      o_count     <= '0;
      o_valid     <= 1'b0;
      o_blankMask <= '0;
      o_error     <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_valid   <= 1'b0;
      o_error   <= 1'b0;
      o_overrun <= 1'b0;
      if (frame_done) begin
        if (err_flag)           o_error   <= 1'b1;
        else if (state != IDLE) o_overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (frame_done && !err_flag) begin
            bcd_lat   <= slot_bcd;
            blank_lat <= slot_blank;
            acc       <= '0;
            idx       <= 2'd3;
            state     <= CONV;
          end
        end
        CONV: begin
          acc <= acc_next;
          idx <= idx - 2'd1;
          if (idx == 2'd0) begin
            state       <= DONE;
            o_valid     <= 1'b1;
            o_count     <= acc_next;
            o_BCD       <= bcd_lat;
            o_blankMask <= blank_lat;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic [TMO_W-1:0] tmo_cnt;

  // Stale watchdog: cleared alongside o_valid, saturates once the timeout is reached.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tmo_cnt <= '0;
      o_stale <= 1'b1;
    end else if (valid_set) begin
      tmo_cnt <= '0;
      o_stale <= 1'b0;
    end else if (tmo_cnt != TMO_W'(TIMEOUT_CYCLES)) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) o_stale <= 1'b1;
    end
  end

endmodule
